// File: rtl/ysyx_22050058_shift_div_if.sv
// EX-stage div/rem handshake between the pipeline (master) and the divider (slave).
interface ysyx_22050058_shift_div_if #(
  parameter int WIDTH = 64
);
  logic             div_ready;
  logic             div_datavalid_i;
  logic             div_signed_i;
  logic             div_word_i;
  logic             div_flush_i;
  logic [WIDTH-1:0] div_dividend_i;
  logic [WIDTH-1:0] div_divisor_i;
  logic             div_doing_o;
  logic             div_qrvalid_o;
  logic [WIDTH-1:0] div_quotient_o;
  logic [WIDTH-1:0] div_remainder_o;

  modport master (
    output div_ready, div_datavalid_i, div_signed_i, div_word_i, div_flush_i,
           div_dividend_i, div_divisor_i,
    input  div_doing_o, div_qrvalid_o, div_quotient_o, div_remainder_o
  );

  modport slave (
    input  div_ready, div_datavalid_i, div_signed_i, div_word_i, div_flush_i,
           div_dividend_i, div_divisor_i,
    output div_doing_o, div_qrvalid_o, div_quotient_o, div_remainder_o
  );
endinterface

// File: rtl/ysyx_22050058_shift_div.sv
// Iterative radix-2 restoring divider with RISC-V M semantics (DIV/DIVU/REM/REMU and W forms).
// Results are held until the pipeline retires them with div_ready.
module ysyx_22050058_shift_div #(
  parameter int WIDTH = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  ysyx_22050058_shift_div_if.slave div_if
);
  localparam int HW = 32;
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, BUSY, FIX, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] dvd;
  logic [WIDTH-1:0] dvs;
  logic [WIDTH-1:0] rem;
  logic [CW-1:0]    counter;
  logic             q_neg;
  logic             r_neg;
  logic             word;

  logic             dvd_sign;
  logic             dvs_sign;
  logic [WIDTH-1:0] dvd_abs;
  logic [WIDTH-1:0] dvs_abs;
  logic [WIDTH-1:0] dvd_ext;
  logic [WIDTH-1:0] dvd_aligned;
  logic             dvs_zero;
  logic             ovf;

  // Operand conditioning at accept time.
  always_comb begin
    dvd_sign    = 1'b0;
    dvs_sign    = 1'b0;
    dvd_abs     = '0;
    dvs_abs     = '0;
    dvd_ext     = '0;
    dvd_aligned = '0;
    dvs_zero    = 1'b0;
    ovf         = 1'b0;
    if (div_if.div_word_i) begin
      dvd_sign    = div_if.div_signed_i & div_if.div_dividend_i[HW-1];
      dvs_sign    = div_if.div_signed_i & div_if.div_divisor_i[HW-1];
      dvd_abs     = {{(WIDTH-HW){1'b0}},
                     dvd_sign ? -div_if.div_dividend_i[HW-1:0] : div_if.div_dividend_i[HW-1:0]};
      dvs_abs     = {{(WIDTH-HW){1'b0}},
                     dvs_sign ? -div_if.div_divisor_i[HW-1:0] : div_if.div_divisor_i[HW-1:0]};
      dvd_ext     = {{(WIDTH-HW){div_if.div_dividend_i[HW-1]}}, div_if.div_dividend_i[HW-1:0]};
      // W dividend sits in the upper half so the MSB-first shift sees only its 32 bits.
      dvd_aligned = {dvd_abs[HW-1:0], {(WIDTH-HW){1'b0}}};
      dvs_zero    = (div_if.div_divisor_i[HW-1:0] == '0);
      ovf         = div_if.div_signed_i
                  && (div_if.div_dividend_i[HW-1:0] == {1'b1, {(HW-1){1'b0}}})
                  && (div_if.div_divisor_i[HW-1:0] == '1);
    end else begin
      dvd_sign    = div_if.div_signed_i & div_if.div_dividend_i[WIDTH-1];
      dvs_sign    = div_if.div_signed_i & div_if.div_divisor_i[WIDTH-1];
      dvd_abs     = dvd_sign ? -div_if.div_dividend_i : div_if.div_dividend_i;
      dvs_abs     = dvs_sign ? -div_if.div_divisor_i : div_if.div_divisor_i;
      dvd_ext     = div_if.div_dividend_i;
      dvd_aligned = dvd_abs;
      dvs_zero    = (div_if.div_divisor_i == '0);
      ovf         = div_if.div_signed_i
                  && (div_if.div_dividend_i == {1'b1, {(WIDTH-1){1'b0}}})
                  && (div_if.div_divisor_i == '1);
    end
  end

  logic [WIDTH:0]   partial;
  logic [WIDTH-1:0] rem_nx;
  logic [WIDTH-1:0] dvd_nx;
  logic [WIDTH-1:0] q_signed;
  logic [WIDTH-1:0] r_signed;
  logic [WIDTH-1:0] q_fin;
  logic [WIDTH-1:0] r_fin;

  // One restoring step; dvd shifts left and collects quotient bits at its LSB.
  always_comb begin
    partial  = {rem, dvd[WIDTH-1]} - {1'b0, dvs};
    rem_nx   = partial[WIDTH] ? {rem[WIDTH-2:0], dvd[WIDTH-1]} : partial[WIDTH-1:0];
    dvd_nx   = {dvd[WIDTH-2:0], ~partial[WIDTH]};
    q_signed = q_neg ? -dvd_nx : dvd_nx;
    r_signed = r_neg ? -rem_nx : rem_nx;
    q_fin    = word ? {{(WIDTH-HW){q_signed[HW-1]}}, q_signed[HW-1:0]} : q_signed;
    r_fin    = word ? {{(WIDTH-HW){r_signed[HW-1]}}, r_signed[HW-1:0]} : r_signed;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state                  <= IDLE;
      dvd                    <= '0;
      dvs                    <= '0;
      rem                    <= '0;
      counter                <= '0;
      q_neg                  <= 1'b0;
      r_neg                  <= 1'b0;
      word                   <= 1'b0;
      div_if.div_doing_o     <= 1'b0;
      div_if.div_qrvalid_o   <= 1'b0;
      div_if.div_quotient_o  <= '0;
      div_if.div_remainder_o <= '0;
    end else if (div_if.div_flush_i) begin
      state                <= IDLE;
      div_if.div_doing_o   <= 1'b0;
      div_if.div_qrvalid_o <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (div_if.div_datavalid_i) begin
            word  <= div_if.div_word_i;
            q_neg <= dvd_sign ^ dvs_sign;
            r_neg <= dvd_sign;
            if (dvs_zero || ovf) begin
              // Special results are staged in dvd/rem and published one cycle later.
              dvd   <= dvs_zero ? '1 : dvd_ext;
              rem   <= dvs_zero ? dvd_ext : '0;
              state <= FIX;
            end else begin
              dvd                <= dvd_aligned;
              dvs                <= dvs_abs;
              rem                <= '0;
              counter            <= div_if.div_word_i ? CW'(HW) : CW'(WIDTH);
              div_if.div_doing_o <= 1'b1;
              state              <= BUSY;
            end
          end
        end
        FIX: begin
          div_if.div_quotient_o  <= dvd;
          div_if.div_remainder_o <= rem;
          div_if.div_qrvalid_o   <= 1'b1;
          state                  <= DONE;
        end
        BUSY: begin
          dvd     <= dvd_nx;
          rem     <= rem_nx;
          counter <= counter - 1'b1;
          if (counter == CW'(1)) begin
            div_if.div_quotient_o  <= q_fin;
            div_if.div_remainder_o <= r_fin;
            div_if.div_doing_o     <= 1'b0;
            div_if.div_qrvalid_o   <= 1'b1;
            state                  <= DONE;
          end
        end
        DONE: begin
          if (div_if.div_ready) begin
            div_if.div_qrvalid_o <= 1'b0;
            state                <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
